// File: rtl/dmem_ctrl.sv
// Big-endian byte-addressed data memory behind a valid/ready request port.
// Word-port storage; accesses that straddle a word boundary take two cycles.
module dmem_ctrl #(
    parameter int DEPTH_BYTES = 256,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int BA_W  = $clog2(DEPTH_BYTES);
    localparam int WORDS = DEPTH_BYTES / 4;
    localparam int WI_W  = BA_W - 2;
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH_BYTES);

    typedef enum logic [0:0] {IDLE = 1'b0, SPLIT = 1'b1} state_e;

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [31:0] extend_load(input logic [31:0] raw, input logic [1:0] size,
                                                input logic sgn);
        case (size)
            2'b00:   return sgn ? {{24{raw[7]}}, raw[7:0]} : {24'h000000, raw[7:0]};
            2'b01:   return sgn ? {{16{raw[15]}}, raw[15:0]} : {16'h0000, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    state_e            state_q, state_d;
    logic [BA_W-1:0]   lat_addr_q, lat_addr_d;
    logic [1:0]        lat_size_q, lat_size_d;
    logic              lat_signed_q, lat_signed_d;
    logic              lat_we_q, lat_we_d;
    logic [31:0]       lat_wdata_q, lat_wdata_d;
    logic [31:0]       acc_q, acc_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic [31:0]       mem_q [WORDS];

    logic [BA_W-1:0]   act_addr_s;
    logic [WI_W-1:0]   act_word_s;
    logic [1:0]        act_size_s;
    logic              act_signed_s;
    logic              act_we_s;
    logic [31:0]       act_wdata_s;
    logic              access_en_s;
    logic [2:0]        n_s;
    logic [3:0]        be_s;
    logic [31:0]       wword_s;
    logic [31:0]       rd_word_s;
    logic [31:0]       raw_s;
    logic [BA_W-1:0]   lane_addr_s;
    logic [BA_W:0]     off_s;
    logic [2:0]        sh_s;
    logic [ADDR_W:0]   end_addr_s;
    logic              req_err_s;
    logic              req_cross_s;
    logic              accept_s;

    assign req_ready   = (state_q == IDLE) && !rst;
    assign accept_s    = req_valid && req_ready;
    // Range check uses the full address so high bits cannot alias into the array.
    assign end_addr_s  = {1'b0, req_addr} + (ADDR_W+1)'(size_bytes(req_size)) - (ADDR_W+1)'(1);
    assign req_err_s   = (req_size == 2'b11) || (end_addr_s >= DEPTH_EXT);
    assign req_cross_s = ({1'b0, req_addr[1:0]} + size_bytes(req_size)) > 3'd4;
    assign rd_word_s   = mem_q[act_word_s];
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;

    // Select the request being served: live inputs in IDLE, latched copy in SPLIT.
    always_comb begin
        if (state_q == SPLIT) begin
            act_addr_s   = lat_addr_q;
            act_word_s   = lat_addr_q[BA_W-1:2] + WI_W'(1);
            act_size_s   = lat_size_q;
            act_signed_s = lat_signed_q;
            act_we_s     = lat_we_q;
            act_wdata_s  = lat_wdata_q;
        end else begin
            act_addr_s   = req_addr[BA_W-1:0];
            act_word_s   = req_addr[BA_W-1:2];
            act_size_s   = req_size;
            act_signed_s = req_signed;
            act_we_s     = req_we;
            act_wdata_s  = req_wdata;
        end
    end

    // Map each lane of the current word onto its big-endian byte position in the access.
    always_comb begin
        be_s        = 4'b0000;
        wword_s     = 32'h0000_0000;
        raw_s       = 32'h0000_0000;
        lane_addr_s = '0;
        off_s       = '0;
        sh_s        = 3'd0;
        n_s         = size_bytes(act_size_s);
        for (int l = 0; l < 4; l++) begin
            lane_addr_s = {act_word_s, 2'(l)};
            off_s       = {1'b0, lane_addr_s} - {1'b0, act_addr_s};
            if (off_s < (BA_W+1)'(n_s)) begin
                sh_s                    = n_s - 3'd1 - {1'b0, off_s[1:0]};
                be_s[l]                 = 1'b1;
                wword_s[(24-8*l) +: 8]  = 8'(act_wdata_s >> {sh_s, 3'b000});
                raw_s                   = raw_s | (32'(rd_word_s[(24-8*l) +: 8]) << {sh_s, 3'b000});
            end else begin
                be_s[l] = 1'b0;
            end
        end
    end

    // Next-state and response logic.
    always_comb begin
        state_d      = state_q;
        lat_addr_d   = lat_addr_q;
        lat_size_d   = lat_size_q;
        lat_signed_d = lat_signed_q;
        lat_we_d     = lat_we_q;
        lat_wdata_d  = lat_wdata_q;
        acc_d        = acc_q;
        rsp_valid_d  = 1'b0;
        rsp_rdata_d  = 32'h0000_0000;
        rsp_err_d    = 1'b0;
        access_en_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    if (req_err_s) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else if (req_cross_s) begin
                        access_en_s  = 1'b1;
                        state_d      = SPLIT;
                        lat_addr_d   = req_addr[BA_W-1:0];
                        lat_size_d   = req_size;
                        lat_signed_d = req_signed;
                        lat_we_d     = req_we;
                        lat_wdata_d  = req_wdata;
                        acc_d        = raw_s;
                    end else begin
                        access_en_s = 1'b1;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = act_we_s ? 32'h0000_0000
                                               : extend_load(raw_s, act_size_s, act_signed_s);
                    end
                end else begin
                    access_en_s = 1'b0;
                end
            end
            SPLIT: begin
                access_en_s = 1'b1;
                state_d     = IDLE;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = act_we_s ? 32'h0000_0000
                                       : extend_load(acc_q | raw_s, act_size_s, act_signed_s);
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            lat_addr_q   <= '0;
            lat_size_q   <= 2'b00;
            lat_signed_q <= 1'b0;
            lat_we_q     <= 1'b0;
            lat_wdata_q  <= 32'h0000_0000;
            acc_q        <= 32'h0000_0000;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= 32'h0000_0000;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            lat_addr_q   <= lat_addr_d;
            lat_size_q   <= lat_size_d;
            lat_signed_q <= lat_signed_d;
            lat_we_q     <= lat_we_d;
            lat_wdata_q  <= lat_wdata_d;
            acc_q        <= acc_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    // Storage is deliberately not cleared by reset; writes are suppressed while it is held.
    always_ff @(posedge clk) begin
        for (int l = 0; l < 4; l++) begin
            if (access_en_s && act_we_s && be_s[l] && !rst) begin
                mem_q[act_word_s][(24-8*l) +: 8] <= wword_s[(24-8*l) +: 8];
            end
        end
    end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Parametrised successor to the byte-addressed data memory.
- Big-endian, byte-addressed data store behind a valid/ready request port and a registered response port.
- Supports byte, half-word and word accesses, optional sign extension, and misaligned accesses (split into two word-port cycles).
- Flags out-of-range and illegal-size requests; sits between the core's load/store unit and on-chip storage.

Parameters:
- DEPTH_BYTES, 256, storage size in bytes; a power of two, multiple of 4.
- ADDR_W, 32, request address width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_signed  in  1  sign-extend byte/half loads.
- req_addr  in  ADDR_W  byte address of the most-significant byte.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  one-cycle pulse: request completed.
- rsp_rdata  out  32  load data, right-aligned and extended; 0 for stores and errors.
- rsp_err  out  1  valid with rsp_valid: out-of-range or illegal size.

Behaviour:
- Storage organisation:
  - DEPTH_BYTES/4 words of 32 bits, with per-byte write enables.
  - One word access per cycle.
  - Memory contents are not cleared by rst.
- Byte order: big-endian. The byte at addr is the MSB of the access; addr+N-1 is the LSB.
- Accept: when req_valid && req_ready at posedge.
- Errors, detected at accept:
  - Error conditions: req_size==11, or addr+N-1 >= DEPTH_BYTES, where N = 1/2/4.
  - On error: no write, no address wrap-around, rsp_err=1, rsp_rdata=0, latency 1.
- FSM states: IDLE, SPLIT.
  - IDLE: req_ready=1.
  - Accepted request that fits within one aligned word (addr[1:0]+N <= 4), or error: stay in IDLE; rsp_valid=1 next cycle.
  - Accepted request that crosses a word boundary: go to SPLIT.
    - The first word (bytes up to the boundary) is accessed in the accept cycle.
    - Address, size, signed flag and data are latched.
  - SPLIT: req_ready=0. The second word (addr+N-1 side) is accessed; return to IDLE. rsp_valid=1 the following cycle.
- Latency and throughput:
  - Single-word: rsp one cycle after accept; back-to-back accepts give one response per cycle.
  - Split: rsp two cycles after accept; one bubble.
- Load data:
  - Assembled from the addressed bytes, right-aligned.
  - Upper bits zero-filled, or sign-filled from the access MSB when req_signed=1 and size is byte/half.
  - req_signed is ignored for word accesses.
- Stores:
  - Write only the addressed bytes using byte enables; other bytes are unchanged.
  - rsp_valid still pulses, with rsp_rdata=0 and rsp_err=0.
- Ordering: a load accepted after a store's response, or back-to-back after a store's accept, returns the stored data (write-first ordering by cycle).
- Reset:
  - Values: state=IDLE, req_ready=1 (the cycle after rst deasserts), rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - While rst=1: requests are not accepted (req_ready=0) and no writes occur.
  - Reset mid-SPLIT: the operation is aborted with no response. The first-word half of a split store remains committed; the second half is not written.
- Address bits above log2(DEPTH_BYTES) participate in the range check; they are not ignored.

Test Plan:
- Reset check: assert rst for 2 cycles with req_valid=1, we=1 -> no write occurs; rsp_valid=0, rsp_rdata=0, rsp_err=0; req_ready=1 after release.
- Aligned word and bytes:
  - Store word 0x11223344 at 0x10 -> rsp_valid, err=0.
  - Byte loads at 0x10..0x13 -> 0x11, 0x22, 0x33, 0x44.
  - Half load at 0x12 -> 0x3344.
- Sign extension:
  - Store byte 0x80 at 0x20; signed byte load -> 0xFFFFFF80; unsigned -> 0x00000080.
  - Signed half load with 0x8001 stored -> 0xFFFF8001.
- Misaligned split:
  - Store word 0xAABBCCDD at 0x1E -> req_ready=0 for one cycle, rsp 2 cycles after accept.
  - Word load at 0x1E -> 0xAABBCCDD; bytes 0x1C/0x1D and 0x22/0x23 are unchanged.
- Errors:
  - Word load at DEPTH_BYTES-2 -> rsp_err=1, rdata=0, latency 1.
  - req_size=11 -> err=1.
  - Store at 0x100 (DEPTH 256) -> err=1 and memory byte 0x00 is unchanged.
- Throughput and mid-split reset:
  - 4 back-to-back aligned loads -> 4 consecutive rsp_valid cycles.
  - Assert rst in the SPLIT cycle of a store at 0x1E -> no rsp; bytes 0x1E-0x1F written, 0x20-0x21 old values.
